// File: rtl/mole_pkg.sv
// mole_pkg: shared types and helpers for the whack-a-mole sequencer.
//   mole_state_t : game FSM state (7 states, 3-bit encoding)
//   ENC_*        : raw state encodings, also visible on the debug port
//   clog2()      : hole-index width for a given hole count (minimum 1)
package mole_pkg;

    localparam logic [2:0] ENC_IDLE = 3'd0;
    localparam logic [2:0] ENC_SEED = 3'd1;
    localparam logic [2:0] ENC_GAP  = 3'd2;
    localparam logic [2:0] ENC_UP   = 3'd3;
    localparam logic [2:0] ENC_HIT  = 3'd4;
    localparam logic [2:0] ENC_MISS = 3'd5;
    localparam logic [2:0] ENC_OVER = 3'd6;

    typedef enum logic [2:0] {
        IDLE = ENC_IDLE,
        SEED = ENC_SEED,
        GAP  = ENC_GAP,
        UP   = ENC_UP,
        HIT  = ENC_HIT,
        MISS = ENC_MISS,
        OVER = ENC_OVER
    } mole_state_t;

    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/mole_scheduler_tick_timer.sv
// tick_timer: game-tick prescaler plus a loadable down-counter of ticks.
//   clk, restart_n : clock, asynchronous active-low reset
//   load           : restart prescaler and load load_val ticks
//   load_val[4:0]  : number of ticks to count
//   done           : one-cycle pulse in the last clock cycle of the final tick,
//                    so a state change on that edge lasts exactly
//                    load_val * TICK_DIV cycles after the load edge
module tick_timer #(
    parameter int TICK_DIV = 50000
) (
    input  logic       clk,
    input  logic       restart_n,
    input  logic       load,
    input  logic [4:0] load_val,
    output logic       done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc;
    logic [4:0]    count;
    logic          tick;

    assign tick = (presc == PW'(TICK_DIV - 1));
    assign done = tick && (count == 5'd1);

    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            presc <= '0;
            count <= '0;
        end else if (load) begin
            presc <= '0;
            count <= load_val;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && count != 5'd0) begin
                count <= count - 5'd1;
            end
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole game sequencer.
//   clk, restart_n : clock, asynchronous active-low reset
//   start          : one-cycle pulse, begins a game from IDLE or OVER
//   rand_sel[7:0]  : LFSR value, sampled on GAP->UP to pick the hole
//   rand_gap[9:0]  : LFSR value, low nibble sampled on GAP entry
//   hit[N_HOLES]   : debounced one-cycle hit pulses
//   rng_restart    : one-cycle pulse to reseed the LFSRs (during SEED)
//   mole           : one-hot active mole or zero
//   score, misses  : per-game counters (score saturates)
//   game_over      : high while in OVER
//   dbg_state      : current FSM state
// All outputs are registered; the registers are written from the next state
// so they line up with the state they describe.
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int N_HOLES    = 8,
    parameter int TICK_DIV   = 50000,
    parameter int GAP_BASE   = 8,
    parameter int UP_BASE    = 16,
    parameter int MAX_MISSES = 5,
    parameter int SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               restart_n,
    input  logic               start,
    input  logic [7:0]         rand_sel,
    input  logic [9:0]         rand_gap,
    input  logic [N_HOLES-1:0] hit,
    output logic               rng_restart,
    output logic [N_HOLES-1:0] mole,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         misses,
    output logic               game_over,
    output mole_state_t        dbg_state
);

    localparam int HW      = clog2(N_HOLES);
    localparam int HALF_UP = UP_BASE / 2;

    mole_state_t       state, nstate;
    logic [HW-1:0]     prev_hole;
    logic [HW-1:0]     raw_hole, sel_hole;
    logic [SCORE_W-1:0] score_q4;
    logic [4:0]        gap_ticks, up_ticks, load_val;
    logic              load, timer_done;
    logic              unused_rand;

    assign dbg_state   = state;
    assign unused_rand = ^{rand_gap[9:4], rand_sel[7:HW]};

    // Hole pick: low bits of rand_sel, bumped by one if it repeats the last
    // hole. N_HOLES is a power of two, so the HW-bit add wraps correctly.
    assign raw_hole = rand_sel[HW-1:0];
    assign sel_hole = (raw_hole == prev_hole) ? raw_hole + HW'(1) : raw_hole;

    // Up time shrinks by one tick per 4 points, floored at UP_BASE/2.
    assign score_q4  = score >> 2;
    assign up_ticks  = (32'(score_q4) >= HALF_UP) ? 5'(HALF_UP)
                                                  : 5'(UP_BASE - int'(score_q4));
    assign gap_ticks = 5'(GAP_BASE) + {1'b0, rand_gap[3:0]};

    tick_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk       (clk),
        .restart_n (restart_n),
        .load      (load),
        .load_val  (load_val),
        .done      (timer_done)
    );

    always_comb begin
        nstate   = state;
        load     = 1'b0;
        load_val = gap_ticks;
        case (state)
            IDLE:    if (start) nstate = SEED;
            SEED:    nstate = GAP;
            GAP:     if (timer_done) nstate = UP;
            // prev_hole already holds the active hole; a hit beats expiry.
            UP: begin
                if (hit[prev_hole])   nstate = HIT;
                else if (timer_done)  nstate = MISS;
            end
            HIT:     nstate = GAP;
            // misses was incremented on the UP->MISS edge.
            MISS:    nstate = (misses == 4'(MAX_MISSES)) ? OVER : GAP;
            OVER:    if (start) nstate = SEED;
            default: nstate = IDLE;
        endcase
        // GAP and UP never overlap, so one timer serves both.
        if (nstate == GAP && state != GAP) begin
            load     = 1'b1;
            load_val = gap_ticks;
        end
        if (nstate == UP && state != UP) begin
            load     = 1'b1;
            load_val = up_ticks;
        end
    end

    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            state       <= IDLE;
            prev_hole   <= '0;
            mole        <= '0;
            score       <= '0;
            misses      <= '0;
            rng_restart <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= nstate;
            rng_restart <= (nstate == SEED);
            game_over   <= (nstate == OVER);

            if (state == GAP && nstate == UP) begin
                prev_hole <= sel_hole;
                mole      <= N_HOLES'(1) << sel_hole;
            end else if (nstate != UP) begin
                mole <= '0;
            end

            if (nstate == SEED) begin
                score <= '0;
            end else if (state == UP && nstate == HIT && score != '1) begin
                score <= score + SCORE_W'(1);
            end

            if (nstate == SEED) begin
                misses <= '0;
            end else if (state == UP && nstate == MISS) begin
                misses <= misses + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler (TICK_DIV=4, N_HOLES=8, MAX_MISSES=3).
// The reference model tracks previous hole, score and misses as plain
// integers and predicts gap/up lengths in cycles from the game rules.
module tb_mole_scheduler;
    import mole_pkg::*;

    localparam int NH = 8;
    localparam int TD = 4;
    localparam int GB = 8;
    localparam int UB = 16;
    localparam int MM = 3;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          restart_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rand_sel = '0;
    logic [9:0]    rand_gap = '0;
    logic [NH-1:0] hit = '0;
    logic          rng_restart;
    logic [NH-1:0] mole;
    logic [SW-1:0] score;
    logic [3:0]    misses;
    logic          game_over;
    mole_state_t   dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int m_prev   = 0;
    int m_score  = 0;
    int m_misses = 0;
    int cur_gap  = 0;
    logic [NH-1:0] exp_q[$];

    always #5 clk = ~clk;

    mole_scheduler #(
        .N_HOLES    (NH),
        .TICK_DIV   (TD),
        .GAP_BASE   (GB),
        .UP_BASE    (UB),
        .MAX_MISSES (MM),
        .SCORE_W    (SW)
    ) dut (
        .clk         (clk),
        .restart_n   (restart_n),
        .start       (start),
        .rand_sel    (rand_sel),
        .rand_gap    (rand_gap),
        .hit         (hit),
        .rng_restart (rng_restart),
        .mole        (mole),
        .score       (score),
        .misses      (misses),
        .game_over   (game_over),
        .dbg_state   (dbg_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_game(input int g);
        cur_gap  = g;
        rand_gap = {6'($urandom), 4'(g)};
        start    = 1'b1;
        step();
        start    = 1'b0;
        m_score  = 0;
        m_misses = 0;
        chk("seed_pulse", 32'(rng_restart), 32'd1);
        chk("seed_state", 32'(dbg_state), 32'(SEED));
        chk("seed_clear", 32'({score, misses}), 32'd0);
        chk("seed_mole_idle", 32'({mole, game_over}), 32'd0);
        step();
        chk("seed_one_cycle", 32'(rng_restart), 32'd0);
        chk("gap_state", 32'(dbg_state), 32'(GAP));
    endtask

    // Called just after a GAP entry edge. timeout=1 lets the mole expire
    // (with wrong-hole hits); otherwise the right hole is hit, on the last
    // up cycle when collide=1.
    task automatic do_mole(input int sel, input bit timeout, input bit collide);
        int n;
        int up;
        int j;
        int h;
        logic [NH-1:0] oh;

        rand_sel = 8'(sel);
        h = sel % NH;
        if (h == m_prev) h = (h + 1) % NH;
        m_prev = h;
        oh = '0;
        oh[h] = 1'b1;
        exp_q.push_back(oh);

        n = 0;
        while (n < 400) begin
            hit   = (n == 2) ? '1 : '0;
            start = (n == 5);
            step();
            n++;
            if (mole !== '0) break;
        end
        hit   = '0;
        start = 1'b0;
        chk("gap_len", 32'(n), 32'((GB + cur_gap) * TD));
        chk("mole_hole", 32'(mole), 32'(exp_q.pop_front()));
        chk("score_in_gap", 32'(score), 32'(m_score));

        cur_gap  = $urandom_range(0, 15);
        rand_gap = {6'($urandom), 4'(cur_gap)};
        rand_sel = 8'($urandom);
        up = (UB - (((m_score / 4) > (UB / 2)) ? (UB / 2) : (m_score / 4))) * TD;

        if (!timeout) begin
            j = collide ? up : $urandom_range(1, up);
            for (int k = 1; k <= j; k++) begin
                hit = NH'($urandom) & ~oh;
                if (k == j) hit = hit | oh;
                step();
            end
            hit = '0;
            m_score = (m_score < 255) ? m_score + 1 : 255;
            chk("hit_mole_drop", 32'(mole), 32'd0);
            chk("hit_score", 32'(score), 32'(m_score));
            chk("hit_misses", 32'(misses), 32'(m_misses));
            step();
            chk("after_hit_state", 32'(dbg_state), 32'(GAP));
        end else begin
            n = 0;
            while (n < 200) begin
                hit = NH'($urandom) & ~oh;
                step();
                n++;
                if (mole === '0) break;
            end
            hit = '0;
            m_misses++;
            chk("up_len", 32'(n), 32'(up));
            chk("miss_count", 32'(misses), 32'(m_misses));
            chk("miss_score", 32'(score), 32'(m_score));
            step();
            chk("after_miss_over", 32'(game_over), 32'(m_misses == MM));
            chk("after_miss_mole", 32'(mole), 32'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit done12;
        bit done64;
        int n;

        // Reset
        restart_n = 1'b0;
        repeat (3) step();
        chk("rst_outputs", 32'({rng_restart, mole, score, misses, game_over}), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        restart_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            hit      = NH'($urandom);
            rand_sel = 8'($urandom);
            rand_gap = 10'($urandom);
            step();
            chk("idle_quiet", 32'({rng_restart, mole, score, misses, game_over}), 32'd0);
        end
        hit = '0;
        chk("idle_state", 32'(dbg_state), 32'(IDLE));

        // Directed game: wrong-hole hit, same-hole avoidance, collision, game over
        start_game(5);
        do_mole(8'h0B, 1'b1, 1'b0);
        do_mole(8'h03, 1'b0, 1'b0);
        do_mole(8'h03, 1'b0, 1'b1);
        do_mole(int'($urandom_range(0, 255)), 1'b1, 1'b0);
        do_mole(int'($urandom_range(0, 255)), 1'b1, 1'b0);
        chk("over_state", 32'(dbg_state), 32'(OVER));
        for (int i = 0; i < 20; i++) begin
            hit = NH'($urandom);
            step();
            chk("over_hold", 32'({game_over, mole, score, misses}),
                32'({1'b1, 8'h00, 8'(m_score), 4'(m_misses)}));
        end
        hit = '0;

        // Long game: speed-up at score 12 and 64, saturation at 255
        start_game($urandom_range(0, 15));
        done12 = 1'b0;
        done64 = 1'b0;
        for (int i = 0; i < 262; i++) begin
            if (m_score == 12 && !done12) begin
                done12 = 1'b1;
                do_mole(int'($urandom_range(0, 255)), 1'b1, 1'b0);
            end else if (m_score == 64 && !done64) begin
                done64 = 1'b1;
                do_mole(int'($urandom_range(0, 255)), 1'b1, 1'b0);
            end else begin
                do_mole(int'($urandom_range(0, 255)), 1'b0, ($urandom_range(0, 7) == 0));
            end
        end
        chk("score_saturated", 32'(score), 32'd255);

        // Asynchronous reset while a mole is up
        n = 0;
        while (n < 400 && mole === '0) begin
            step();
            n++;
        end
        chk("mole_up_before_reset", 32'(mole !== '0), 32'd1);
        #2;
        restart_n = 1'b0;
        #1;
        chk("async_mole_drop", 32'(mole), 32'd0);
        chk("async_state", 32'(dbg_state), 32'(IDLE));
        chk("async_counters", 32'({score, misses, game_over, rng_restart}), 32'd0);
        #3;
        restart_n = 1'b1;
        m_prev = 0;
        exp_q.delete();
        repeat (5) step();
        chk("post_reset_idle", 32'(dbg_state), 32'(IDLE));

        // Previous hole resets to 0, so rand_sel=0 must land on hole 1
        start_game($urandom_range(0, 15));
        do_mole(8'h00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
